rot_shift_seq: RTL
==================

# rot_shift_seq

Parametrised, multi-cycle shift/rotate register with parallel load and a start/busy/done handshake. It is the general-width successor of the lab's 8-bit rotating shift register. It adds left/right rotation, logical and arithmetic right shift, and a programmable shift amount executed one position per clock. It sits between switch/key input logic and LED/datapath consumers, and is driven by a controller that issues `start` and waits for `done`.

## Interface
Parameters:
- `WIDTH`, default 8: register width in bits, must be ≥ 2.
- `AMT_W` (localparam): `$clog2(WIDTH)+1`, the width of the `amount` port.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `loadn`  in  1  parallel load, active-low; loads `d` into `q`.
- `d`  in  WIDTH  parallel load data.
- `start`  in  1  request a shift operation; sampled only in IDLE.
- `amount`  in  AMT_W  number of positions to shift; values > WIDTH clamp to WIDTH.
- `mode`  in  2  operation select: 00 ROR, 01 ROL, 10 LSR (zero fill), 11 ASR (MSB fill).
- `q`  out  WIDTH  register contents.
- `busy`  out  1  high while a shift operation is in progress.
- `done`  out  1  one-cycle pulse when an operation completes.
- `cout`, `zero`  out  1 each  flags, present only with `ROT_SHIFT_FLAGS_EN` (see Configuration).

## Operation
- States are IDLE and BUSY. Internal registers:
  - `cnt` (AMT_W bits), the remaining shift count.
  - `mode_r` (2 bits), the mode latched at start.
- Per-edge priority is `resetn` low, then `loadn` low, then state action.
- Reset:
  - `q`=0, `busy`=0, `done`=0, `cnt`=0.
  - State goes to IDLE.
  - Flags are 0.
- Load (`loadn`=0):
  - `q` ← `d`, state goes to IDLE, `busy`=0, `done`=0.
  - In BUSY this aborts the operation; no `done` is produced.
- IDLE with `start`=1:
  - The clamped amount N is latched into `cnt` and `mode` into `mode_r`.
  - N>0: go to BUSY.
  - N=0: stay in IDLE, `q` is unchanged, `done`=1 in the next cycle.
- IDLE with `start`=0: hold `q`.
- BUSY, each edge:
  - `q` shifts one position per `mode_r` and `cnt` decrements.
  - When `cnt`=1 before the edge, go to IDLE and pulse `done`.
- `start` while in BUSY is ignored and is not queued. `mode` and `amount` changes during BUSY have no effect.
- One-position shift definitions:
  - ROR: `q` ← {q[0], q[WIDTH-1:1]}
  - ROL: `q` ← {q[WIDTH-2:0], q[WIDTH-1]}
  - LSR: `q` ← {1'b0, q[WIDTH-1:1]}
  - ASR: `q` ← {q[WIDTH-1], q[WIDTH-1:1]}
- Boundary cases:
  - Rotate by WIDTH returns the original value.
  - LSR by WIDTH gives 0.
  - ASR by WIDTH gives all copies of the original MSB.

## Timing
- `start` is accepted at edge k with N>0:
  - Shifts occur on edges k+1 … k+N.
  - `busy`=1 from after edge k through the cycle before edge k+N.
  - `done`=1 for exactly the one cycle after edge k+N.
- With N=0, `done` is high for the cycle after edge k and `busy` never rises.
- `done` and `busy` are never high in the same cycle.
- A new `start` may be asserted in the same cycle that `done` is high and is accepted, because the block is then in IDLE.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- Macro: `ROT_SHIFT_FLAGS_EN`.
- Defined:
  - `cout` and `zero` ports exist.
  - `cout` is the bit shifted out on the most recent shift edge. For ROR/LSR/ASR that is the old q[0]; for ROL it is the old q[WIDTH-1].
  - `cout` holds otherwise and is cleared by reset or load.
  - `zero` is registered and equals (next `q` == 0), updated on every edge where `q` is written.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset: hold `resetn`=0 for 2 edges with `loadn`=0, `start`=1 → `q`=0x00, `busy`=0, `done`=0 (WIDTH=8).
- ROR: load 0xA5, `start` with `mode`=00, `amount`=3 → `busy` high 3 cycles, `q`=0xB4, `done` pulses once, 4 edges after the start edge.
- Right shifts: load 0x90 then ASR by 2 → 0xE4; load 0x90 then LSR by 2 → 0x24.
- Boundaries:
  - ROL by 8 on 0x3C → 0x3C after 8 busy cycles.
  - `amount`=0 → `done` next cycle, `q` unchanged, `busy` stays 0.
  - `amount`=12 with LSR on 0xFF → 0x00 after 8 shifts.
- Abort and ignore: load 0x81, ROL by 5; on the 2nd busy cycle assert `loadn` with `d`=0x0F → `q`=0x0F, `busy`=0, no `done`. Separately, `start` pulsed mid-BUSY → no extra shifts.
- Flags (with `ROT_SHIFT_FLAGS_EN`):
  - ROL 1 on 0x80 → `q`=0x01, `cout`=1, `zero`=0.
  - LSR 1 on 0x01 → `q`=0x00, `cout`=1, `zero`=1.

Source files
------------

// File: rtl/rot_shift_seq.sv
// rtl/rot_shift_seq.sv - multi-cycle shift/rotate register with load and start/busy/done handshake; optional cout/zero flags via ROT_SHIFT_FLAGS_EN
module rot_shift_seq #(
    parameter int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             loadn,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
`ifdef ROT_SHIFT_FLAGS_EN
    ,
    output logic             cout,
    output logic             zero
`endif
);

    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_LSR = 2'b10;
    localparam logic [1:0] MODE_ASR = 2'b11;

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [AMT_W-1:0] cnt;
    logic [1:0]       mode_r;
    logic [AMT_W-1:0] amt_clamp;
    logic [WIDTH-1:0] shift_q;
    logic             shift_out;

    // Amounts beyond the register width behave exactly like a full-width shift
    always_comb begin
        amt_clamp = amount;
        if (amount > AMT_MAX) begin
            amt_clamp = AMT_MAX;
        end
    end

    // One-position shift of the current contents using the latched mode, plus the bit that falls out
    always_comb begin
        shift_q   = q;
        shift_out = q[0];
        case (mode_r)
            MODE_ROR: shift_q = {q[0], q[WIDTH-1:1]};
            MODE_ROL: begin
                shift_q   = {q[WIDTH-2:0], q[WIDTH-1]};
                shift_out = q[WIDTH-1];
            end
            MODE_LSR: shift_q = {1'b0, q[WIDTH-1:1]};
            MODE_ASR: shift_q = {q[WIDTH-1], q[WIDTH-1:1]};
            default:  shift_q = q;
        endcase
    end

    // Control FSM and datapath: reset beats load, load beats any shift activity
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= IDLE;
            q      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            mode_r <= MODE_ROR;
`ifdef ROT_SHIFT_FLAGS_EN
            cout   <= 1'b0;
            zero   <= 1'b0;
`endif
        end else if (!loadn) begin
            state <= IDLE;
            q     <= d;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef ROT_SHIFT_FLAGS_EN
            cout  <= 1'b0;
            zero  <= (d == '0);
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cnt    <= amt_clamp;
                        mode_r <= mode;
                        if (amt_clamp != '0) begin
                            state <= BUSY;
                            busy  <= 1'b1;
                        end else begin
                            // zero-length request completes immediately without touching q
                            done <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    q   <= shift_q;
                    cnt <= cnt - AMT_W'(1);
`ifdef ROT_SHIFT_FLAGS_EN
                    cout <= shift_out;
                    zero <= (shift_q == '0);
`endif
                    if (cnt == AMT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifndef ROT_SHIFT_FLAGS_EN
    logic unused_shift_out;
    assign unused_shift_out = shift_out;
`endif

endmodule
